// File: rtl/imem_arb_pkg.sv
// Shared constants for the instruction-memory arbiter: owner encoding and default fairness limit.
// Optional host lock port is enabled with IMEM_ARB_HOST_LOCK_EN (see imem_arbiter).
package imem_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE    = 2'd0;
    localparam owner_t OWN_FETCH   = 2'd1;
    localparam owner_t OWN_HOST_RD = 2'd2;

    localparam int FETCH_RUN_MAX_DEF = 4;

endpackage

// File: rtl/imem_arb_fair_cnt.sv
// Saturating starvation counter: counts fetch grants taken while the host waits
// and raises host_force once the fetch run reaches the limit.
module imem_arb_fair_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic host_force
);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            starve_cnt <= 4'd0;
        end else if (inc && (starve_cnt != 4'(LIMIT))) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign host_force = (starve_cnt == 4'(LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between IF fetch (priority) and a host port.
// Define IMEM_ARB_HOST_LOCK_EN to add the host_lock input that shuts fetch out entirely.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int data_width      = 32,
    parameter int imem_addr_width = 8,
    parameter int FETCH_RUN_MAX   = FETCH_RUN_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef IMEM_ARB_HOST_LOCK_EN
    input  logic                       host_lock,
`endif
    input  logic                       fetch_req,
    input  logic [imem_addr_width-1:0] fetch_addr,
    output logic                       fetch_gnt,
    output logic                       fetch_rvalid,
    output logic [data_width-1:0]      fetch_rdata,
    input  logic                       host_req,
    input  logic                       host_wen,
    input  logic [imem_addr_width-1:0] host_addr,
    input  logic [data_width-1:0]      host_wdata,
    output logic                       host_gnt,
    output logic                       host_rvalid,
    output logic [data_width-1:0]      host_rdata,
    output logic [imem_addr_width-1:0] mem_addr,
    output logic [data_width-1:0]      mem_din,
    output logic                       mem_wen,
    input  logic [data_width-1:0]      mem_dout,
    output logic                       pc_hold
);

    logic                  lock;
    logic                  host_force;
    owner_t                owner_d;
    owner_t                owner_p1;
    logic [data_width-1:0] fetch_rdata_q;
    logic [data_width-1:0] host_rdata_q;

`ifdef IMEM_ARB_HOST_LOCK_EN
    assign lock = host_lock;
`else
    assign lock = 1'b0;
`endif

    always_comb begin
        host_gnt  = 1'b0;
        fetch_gnt = 1'b0;
        if (!reset) begin
            if (host_req && (lock || !fetch_req || host_force)) begin
                host_gnt = 1'b1;
            end else if (fetch_req && !lock) begin
                fetch_gnt = 1'b1;
            end
        end
    end

    imem_arb_fair_cnt #(
        .LIMIT (FETCH_RUN_MAX)
    ) u_fair_cnt (
        .clk        (clk),
        .reset      (reset),
        .inc        (fetch_gnt & host_req),
        .clr        (host_gnt | ~host_req | lock),
        .host_force (host_force)
    );

    // Idle cycles keep the PC on the address bus so the memory pre-reads the next fetch.
    assign mem_addr = host_gnt ? host_addr : fetch_addr;
    assign mem_din  = host_wdata;
    assign mem_wen  = host_gnt & host_wen;
    assign pc_hold  = fetch_req & ~fetch_gnt;

    always_comb begin
        owner_d = OWN_NONE;
        if (fetch_gnt) begin
            owner_d = OWN_FETCH;
        end else if (host_gnt && !host_wen) begin
            owner_d = OWN_HOST_RD;
        end
    end

    // Stage 1: memory returns the word granted last cycle; reset drops a pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_p1      <= OWN_NONE;
            fetch_rdata_q <= '0;
            host_rdata_q  <= '0;
        end else begin
            owner_p1 <= owner_d;
            if (fetch_rvalid) fetch_rdata_q <= mem_dout;
            if (host_rvalid)  host_rdata_q  <= mem_dout;
        end
    end

    assign fetch_rvalid = ~reset & (owner_p1 == OWN_FETCH);
    assign host_rvalid  = ~reset & (owner_p1 == OWN_HOST_RD);
    assign fetch_rdata  = fetch_rvalid ? mem_dout : fetch_rdata_q;
    assign host_rdata   = host_rvalid  ? mem_dout : host_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a registered-read memory model on the mem_* ports.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_lock;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        host_req;
    logic        host_wen;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [31:0] mem_dout;
    logic        pc_hold;

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
`ifdef IMEM_ARB_HOST_LOCK_EN
        .host_lock    (host_lock),
`endif
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .host_req     (host_req),
        .host_wen     (host_wen),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_wen      (mem_wen),
        .mem_dout     (mem_dout),
        .pc_hold      (pc_hold)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic fr, input logic [7:0] fa, input logic hr,
                          input logic hw, input logic [7:0] ha, input logic [31:0] hd);
        fetch_req  = fr;
        fetch_addr = fa;
        host_req   = hr;
        host_wen   = hw;
        host_addr  = ha;
        host_wdata = hd;
    endtask

    initial begin
        logic h;
        logic prev_h;
        logic prev_f;
        logic [31:0] idx32;

        reset     = 1'b1;
        host_lock = 1'b0;
        set_in(1'b1, 8'h04, 1'b1, 1'b0, 8'h20, 32'h0);

        // Reset: no grants, no write, idle address is the fetch address
        #1;
        chk("rst_fgnt",   fetch_gnt,    0);
        chk("rst_hgnt",   host_gnt,     0);
        chk("rst_wen",    mem_wen,      0);
        chk("rst_hold",   pc_hold,      1);
        chk("rst_frv",    fetch_rvalid, 0);
        chk("rst_hrv",    host_rvalid,  0);
        chk("rst_maddr",  mem_addr,     32'h04);
        tick();
        chk("rst_frdata", fetch_rdata,  0);
        chk("rst_hrdata", host_rdata,   0);
        chk("rst_fgnt2",  fetch_gnt,    0);
        tick();

        // Preload via host writes with fetch idle
        reset = 1'b0;
        set_in(1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 32'h0000_0011);
        #1;
        chk("pre_hgnt",  host_gnt, 1);
        chk("pre_wen",   mem_wen,  1);
        chk("pre_maddr", mem_addr, 32'h04);
        tick();
        set_in(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'hA5A5_0010);
        tick();
        set_in(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'h0000_0022);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("pre_hrv", host_rvalid, 0);
        tick();

        // Continuous fetch of 0x04
        set_in(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("f1_gnt", fetch_gnt,    1);
        chk("f1_hold", pc_hold,     0);
        chk("f1_rv0", fetch_rvalid, 0);
        tick();
        chk("f1_gnt2",  fetch_gnt,    1);
        chk("f1_rv1",   fetch_rvalid, 1);
        chk("f1_data1", fetch_rdata,  32'h0000_0011);
        chk("f1_hold2", pc_hold,      0);
        tick();
        chk("f1_rv2",   fetch_rvalid, 1);
        chk("f1_data2", fetch_rdata,  32'h0000_0011);
        tick();
        set_in(1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("f1_rv3",   fetch_rvalid, 1);
        chk("f1_gnt3",  fetch_gnt,    0);
        chk("f1_hold3", pc_hold,      0);
        tick();
        chk("f1_rv4",   fetch_rvalid, 0);
        chk("f1_hldat", fetch_rdata,  32'h0000_0011);

        // Fairness: F,F,F,F,H,F,F,F,F,H
        set_in(1'b1, 8'h04, 1'b1, 1'b0, 8'h10, 32'h0);
        prev_h = 1'b0;
        prev_f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            h = (i == 4) || (i == 9);
            #1;
            chk("fair_hgnt", host_gnt,     h);
            chk("fair_fgnt", fetch_gnt,    !h);
            chk("fair_hold", pc_hold,      h);
            chk("fair_hrv",  host_rvalid,  prev_h);
            chk("fair_frv",  fetch_rvalid, prev_f);
            idx32 = h ? 32'h10 : 32'h04;
            chk("fair_maddr", mem_addr, idx32);
            if (prev_h) chk("fair_hdata", host_rdata, 32'hA5A5_0010);
            if (prev_f) chk("fair_fdata", fetch_rdata, 32'h0000_0011);
            tick();
            prev_h = h;
            prev_f = !h;
        end
        set_in(1'b0, 8'h04, 1'b0, 1'b0, 8'h10, 32'h0);
        #1;
        chk("fair_hrv_end",  host_rvalid, 1);
        chk("fair_hdat_end", host_rdata,  32'hA5A5_0010);
        tick();

        // Host write then fetch of the same word
        set_in(1'b0, 8'h04, 1'b1, 1'b1, 8'h08, 32'hDEAD_BEEF);
        #1;
        chk("wr_hgnt", host_gnt, 1);
        chk("wr_wen",  mem_wen,  1);
        chk("wr_din",  mem_din,  32'hDEAD_BEEF);
        tick();
        set_in(1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("wr_fgnt", fetch_gnt,   1);
        chk("wr_hrv",  host_rvalid, 0);
        tick();
        set_in(1'b0, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("wr_frv",   fetch_rvalid, 1);
        chk("wr_fdata", fetch_rdata,  32'hDEAD_BEEF);
        chk("wr_hrv2",  host_rvalid,  0);
        tick();

        // host_req drops after 3 fetch grants: counter clears
        set_in(1'b1, 8'h04, 1'b1, 1'b0, 8'h20, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drop_fgnt", fetch_gnt, 1);
            tick();
        end
        host_req = 1'b0;
        #1;
        chk("drop_fgnt_idle", fetch_gnt, 1);
        tick();
        host_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            h = (i == 4);
            #1;
            chk("drop_hgnt", host_gnt,  h);
            chk("drop_fgnt", fetch_gnt, !h);
            tick();
        end
        set_in(1'b0, 8'h04, 1'b0, 1'b0, 8'h20, 32'h0);
        #1;
        chk("drop_hrv",   host_rvalid, 1);
        chk("drop_hdata", host_rdata,  32'h0000_0022);
        tick();

        // Reset in the cycle after a fetch grant
        set_in(1'b1, 8'h04, 1'b0, 1'b0, 8'h20, 32'h0);
        #1;
        chk("rr_fgnt", fetch_gnt, 1);
        tick();
        reset    = 1'b1;
        host_req = 1'b1;
        #1;
        chk("rr_frv",   fetch_rvalid, 0);
        chk("rr_fgnt2", fetch_gnt,    0);
        chk("rr_hgnt",  host_gnt,     0);
        chk("rr_wen",   mem_wen,      0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            h = (i == 4);
            #1;
            if (i == 0) chk("rr_frv_after", fetch_rvalid, 0);
            chk("rr_hgnt_seq", host_gnt,  h);
            chk("rr_fgnt_seq", fetch_gnt, !h);
            tick();
        end
        set_in(1'b0, 8'h04, 1'b0, 1'b0, 8'h20, 32'h0);
        #1;
        chk("rr_hrv",   host_rvalid, 1);
        chk("rr_hdata", host_rdata,  32'h0000_0022);
        tick();

`ifdef IMEM_ARB_HOST_LOCK_EN
        // Host lock shuts fetch out; release is immediate
        host_lock = 1'b1;
        set_in(1'b1, 8'h04, 1'b0, 1'b0, 8'h10, 32'h0);
        for (int i = 0; i < 6; i++) begin
            host_req = (i == 2);
            #1;
            chk("lock_fgnt", fetch_gnt, 0);
            chk("lock_hold", pc_hold,   1);
            chk("lock_hgnt", host_gnt,  (i == 2));
            tick();
        end
        host_lock = 1'b0;
        host_req  = 1'b0;
        #1;
        chk("unlock_fgnt", fetch_gnt, 1);
        chk("unlock_hold", pc_hold,   0);
        tick();
        set_in(1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port instruction memory between the IF-stage fetch path and a host loader/debug port, so programs can be written into and read back from instruction memory while the pipeline runs. Sits between the fetch stage's PC and the `MEM` instance. Fetch has priority, and a fairness counter guarantees the host a slot. Drives `pc_hold` so the fetch stage freezes its PC in any cycle its access is not granted.

## Interface
- `data_width`, 32, memory word width
- `imem_addr_width`, 8, instruction-memory address width
- `FETCH_RUN_MAX`, 4, consecutive fetch grants allowed while host is waiting (1..15)

- `clk` in 1: sole clock, all state updates on posedge
- `reset` in 1: synchronous, active-high
- `fetch_req` in 1: fetch wants a read this cycle
- `fetch_addr` in `imem_addr_width`: fetch read address (PC)
- `fetch_gnt` out 1: fetch owns memory this cycle
- `fetch_rvalid` out 1: `fetch_rdata` valid
- `fetch_rdata` out `data_width`: fetched instruction
- `host_req` in 1: host wants an access
- `host_wen` in 1: 1 = write, 0 = read
- `host_addr` in `imem_addr_width`: host address
- `host_wdata` in `data_width`: host write data
- `host_gnt` out 1: host owns memory this cycle
- `host_rvalid` out 1: `host_rdata` valid (reads only)
- `host_rdata` out `data_width`: host read data
- `mem_addr` out `imem_addr_width`: to `MEM.addr`
- `mem_din` out `data_width`: to `MEM.din`
- `mem_wen` out 1: to `MEM.wen`
- `mem_dout` in `data_width`: from `MEM.dout`, registered read, valid 1 cycle after address
- `pc_hold` out 1: `fetch_req & ~fetch_gnt`

## Operation
- Grant is combinational, and at most one grant is issued per cycle.
  - Host wins when `host_req` is high and either `fetch_req` is low or `starve_cnt == FETCH_RUN_MAX`.
  - Otherwise fetch wins when `fetch_req` is high.
- Memory mux:
  - Granted requester's address drives `mem_addr`.
  - `mem_wen = host_gnt & host_wen`.
  - `mem_din = host_wdata`.
  - With no grant: `mem_addr` holds the fetch address and `mem_wen` = 0.
- `starve_cnt` (4 bits) behaviour:
  - Increments on each fetch grant while `host_req` is high.
  - Clears on host grant or when `host_req` is low.
  - Saturates at `FETCH_RUN_MAX`.
- Owner register states, updated each cycle from the grant: OWN_NONE, OWN_FETCH, OWN_HOST_RD. A host write records OWN_NONE.
- Read return (1 cycle after grant):
  - OWN_FETCH → `fetch_rvalid` = 1.
  - OWN_HOST_RD → `host_rvalid` = 1.
  - `mem_dout` is routed to the matching rdata. The rdata outputs hold their last value otherwise.
- During `reset` all grants are forced to 0 and `mem_wen` = 0.

## Timing
- Reset values:
  - `starve_cnt` = 0, owner = OWN_NONE.
  - `fetch_rvalid` = `host_rvalid` = 0.
  - `fetch_rdata` = `host_rdata` = 0.
  - All grants = 0 during reset.
- Read latency: grant cycle N → rvalid and data in cycle N+1. Back-to-back grants give one word per cycle.
- Write is committed at the posedge ending the grant cycle. A read of the same address granted in the next cycle returns the new data.
- `pc_hold` is combinational in the same cycle as the lost grant. The IF stage must not advance the PC while it is high.
- Reset asserted in the cycle after a grant suppresses that cycle's rvalid; the pending read is dropped.
- Requesters keep `*_req`, address and data stable until granted. Deasserting before grant is legal and has no effect.

## Configuration
- `IMEM_ARB_HOST_LOCK_EN` defined:
  - Adds input `host_lock` (1).
  - While `host_lock` is high, `fetch_gnt` = 0 regardless of requests, and `pc_hold` follows `fetch_req`.
  - Host is granted whenever it requests, and `starve_cnt` is held at 0.
  - Release takes effect in the same cycle.
  - Used for program download with the core halted.
- Not defined: no `host_lock` port; fairness arbitration only.

## Structure
- Package `imem_arb_pkg`:
  - Owner encoding: OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_HOST_RD = 2'd2.
  - Default `FETCH_RUN_MAX` constant.
- One sub-module, `imem_arb_fair_cnt`: the saturating starvation counter with inc/clear/limit compare, outputting `host_force`.
- The memory itself stays outside the arbiter; the `MEM` instance is moved out of the fetch stage and wired to the `mem_*` ports.

## Test plan
- Preload 0x00000011 at 0x04; hold `fetch_req` = 1 at `fetch_addr` 0x04 → `fetch_gnt` every cycle, and next cycle `fetch_rvalid` = 1 with `fetch_rdata` = 0x00000011, `pc_hold` = 0.
- Both requesting continuously (host read), `FETCH_RUN_MAX` = 4 → grant sequence F,F,F,F,H,F,F,F,F,H; `pc_hold` = 1 exactly in H cycles; `host_rvalid` one cycle after each H.
- Host write 0xDEADBEEF to 0x08, then fetch 0x08 next cycle → `fetch_rdata` = 0xDEADBEEF; `host_rvalid` never asserts for the write.
- `host_req` drops after 3 fetch grants, then reasserts → counter clears; the host again waits 4 fetch grants.
- Reset asserted the cycle after a fetch grant → `fetch_rvalid` = 0 the following cycle, no grants during reset, `starve_cnt` = 0 after.
- With `IMEM_ARB_HOST_LOCK_EN`, `host_lock` = 1 for 6 cycles with `fetch_req` = 1 → `fetch_gnt` = 0 and `pc_hold` = 1 all 6 cycles; on release, `fetch_gnt` = 1 in the same cycle.
